// File: rtl/lzw_dict_bank_ram.sv
// lzw_dict_bank_ram: bank-interleaved single-port dictionary RAM for the LZW
// encoder, with a registered read select, a held read output, a read-valid
// strobe and a hardware table-clear sequencer.
// Optional build macro: LZW_DICT_RAM_OUTREG_EN adds an output pipeline stage
// after the bank mux, so read latency (and rd_valid) becomes 2 cycles.

// One synchronous single-port bank; the read word is registered in the bank.
module lzw_dict_bank #(
    parameter int DATA_W = 8,
    parameter int ROW_W  = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ROW_W];
    logic [DATA_W-1:0] rdata_q;

    // Array write or registered read; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we)
            mem_q[row] <= wdata;
        else if (re)
            rdata_q <= mem_q[row];
    end

    assign rdata = rdata_q;
endmodule

module lzw_dict_bank_ram #(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 12,
    parameter int              BANK_BITS = 3,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wren,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              init_req,
    output logic              busy
);
    localparam int NBANKS = 1 << BANK_BITS;
    localparam int ROW_W  = ADDR_W - BANK_BITS;
    localparam int SEL_W  = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                         state_q, state_d;
    logic [ROW_W-1:0]               cnt_q, cnt_d;
    logic [SEL_W-1:0]               sel_q, sel_d;
    logic                           vld_q, vld_d;
    logic [DATA_W-1:0]              hold_q, hold_d;

    logic [SEL_W-1:0]               addr_sel;
    logic [ROW_W-1:0]               addr_row;
    logic                           acc_rd, acc_wr, clearing;
    logic [NBANKS-1:0]              bank_we, bank_re;
    logic [ROW_W-1:0]               bank_row;
    logic [DATA_W-1:0]              bank_wdata;
    logic [NBANKS-1:0][DATA_W-1:0]  bank_rd;
    logic [DATA_W-1:0]              mux_rd;
    logic [DATA_W-1:0]              rd_s1;

    // Bank index comes from the low address bits; a single bank has index 0.
    if (BANK_BITS > 0) begin : g_sel
        assign addr_sel = addr[BANK_BITS-1:0];
    end else begin : g_nosel
        assign addr_sel = '0;
    end
    assign addr_row = addr[ADDR_W-1:BANK_BITS];

    assign clearing = (state_q == CLEAR);
    assign busy     = clearing;
    // Accesses are simply dropped while the clear sequencer owns the banks.
    assign acc_rd   = en && !wren && !clearing;
    assign acc_wr   = en &&  wren && !clearing;

    // Per-bank strobes: clear writes every bank at once, accesses hit one bank.
    always_comb begin
        bank_we    = '0;
        bank_re    = '0;
        bank_row   = clearing ? cnt_q : addr_row;
        bank_wdata = clearing ? INIT_VAL : wr_data;
        for (int b = 0; b < NBANKS; b++) begin
            bank_we[b] = clearing || (acc_wr && (addr_sel == SEL_W'(b)));
            bank_re[b] = acc_rd && (addr_sel == SEL_W'(b));
        end
    end

    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        lzw_dict_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .re    (bank_re[g]),
            .row   (bank_row),
            .wdata (bank_wdata),
            .rdata (bank_rd[g])
        );
    end

    // Clear sequencer next state: sweep every row once, never wrap the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (init_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == '1)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read path: mux from the registered select, otherwise show the held word.
    always_comb begin
        sel_d  = acc_rd ? addr_sel : sel_q;
        vld_d  = acc_rd;
        mux_rd = '0;
        for (int b = 0; b < NBANKS; b++)
            if (sel_q == SEL_W'(b))
                mux_rd = bank_rd[b];
        rd_s1  = vld_q ? mux_rd : hold_q;
        hold_d = rd_s1;
    end

    // Control and read-hold state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            hold_q  <= hold_d;
        end
    end

`ifdef LZW_DICT_RAM_OUTREG_EN
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_vld_q, out_vld_d;

    // Output stage copies the held first stage, so it holds too.
    always_comb begin
        out_d     = rd_s1;
        out_vld_d = vld_q;
    end

    // Output pipeline register after the bank mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign rd_data  = out_q;
    assign rd_valid = out_vld_q;
`else
    assign rd_data  = rd_s1;
    assign rd_valid = vld_q;
`endif
endmodule

// File: tb/tb_lzw_dict_bank_ram.sv
// Directed bench for lzw_dict_bank_ram with default parameters.
module tb_lzw_dict_bank_ram;
`ifdef LZW_DICT_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, wren = 1'b0, init_req = 1'b0;
    logic [11:0] addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  rd_data;
    logic        rd_valid, busy;

    int n_tests = 0;
    int n_fail  = 0;

    lzw_dict_bank_ram dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wren(wren), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .init_req(init_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        en = 1'b1; wren = 1'b1; addr = a; wr_data = d;
        tick();
        en = 1'b0; wren = 1'b0;
    endtask

    // Single read, result checked after the configured latency.
    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [7:0] exp);
        en = 1'b1; wren = 1'b0; addr = a;
        tick();
        en = 1'b0; addr = '0;
        repeat (LAT - 1) tick();
        check({tag, "_vld"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        tick();
        check({tag, "_pulse"}, 32'(rd_valid), 32'd0);
    endtask

    // Count busy cycles until the clear ends, hammering accesses meanwhile.
    task automatic run_clear(output int n, output int stray_vld);
        n = 0;
        stray_vld = 0;
        while (busy && n < 2000) begin
            en = 1'b1;
            wren = n[0];
            addr = n[0] ? 12'h000 : 12'h5A3;
            wr_data = 8'h77;
            n++;
            tick();
            if (rd_valid) stray_vld++;
        end
        en = 1'b0; wren = 1'b0;
        repeat (LAT) begin
            tick();
            if (rd_valid) stray_vld++;
        end
    endtask

    initial begin
        int n, stray;

        // Reset state
        #2;
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        #20;
        rst_n = 1'b1;
        tick();

        // Write then read next cycle
        wr(12'h5A3, 8'hC4);
        rd_chk("raw_5a3", 12'h5A3, 8'hC4);

        // Bank interleave: back-to-back reads of 0..7
        for (int i = 0; i < 8; i++) wr(12'(i), 8'(8'h10 + i));
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) begin
                en = 1'b1; wren = 1'b0; addr = 12'(i);
            end else begin
                en = 1'b0;
            end
            tick();
            if (i >= LAT - 1) begin
                check($sformatf("b2b_vld_%0d", i - LAT + 1), 32'(rd_valid), 32'd1);
                check($sformatf("b2b_data_%0d", i - LAT + 1), 32'(rd_data), 32'(8'h10 + i - LAT + 1));
            end
        end
        en = 1'b0;
        tick();
        check("b2b_end_vld", 32'(rd_valid), 32'd0);

        // Hold across idle and write cycles
        wr(12'h7FF, 8'h3E);
        rd_chk("hold_rd", 12'h7FF, 8'h3E);
        for (int k = 0; k < 10; k++) begin
            if (k[0]) wr(12'(12'h100 + k), 8'(8'hA0 + k));
            else tick();
            check($sformatf("hold_data_%0d", k), 32'(rd_data), 32'h3E);
            check($sformatf("hold_vld_%0d", k), 32'(rd_valid), 32'd0);
        end

        // Async reset mid-traffic: outputs clear without a clock edge
        en = 1'b1; wren = 1'b0; addr = 12'h7FF;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd_data", 32'(rd_data), 32'd0);
        check("arst_rd_valid", 32'(rd_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        en = 1'b0;
        #10;
        rst_n = 1'b1;
        tick();

        // Clear: fill table, pulse init_req, measure busy, check contents
        for (int a = 0; a < 4096; a++) wr(12'(a), 8'($urandom_range(1, 255)));
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        check("clr_busy_start", 32'(busy), 32'd1);
        run_clear(n, stray);
        check("clr_busy_cycles", 32'(n), 32'd512);
        check("clr_no_rd_valid", 32'(stray), 32'd0);
        rd_chk("clr_000", 12'h000, 8'h00);
        rd_chk("clr_5a3", 12'h5A3, 8'h00);
        rd_chk("clr_fff", 12'hFFF, 8'h00);

        // Read issued together with init_req completes, clear starts same edge
        wr(12'h010, 8'hAB);
        en = 1'b1; wren = 1'b0; addr = 12'h010; init_req = 1'b1;
        tick();
        en = 1'b0; init_req = 1'b0;
        check("rdclr_busy", 32'(busy), 32'd1);
        repeat (LAT - 1) tick();
        check("rdclr_vld", 32'(rd_valid), 32'd1);
        check("rdclr_data", 32'(rd_data), 32'hAB);
        run_clear(n, stray);
        check("rdclr_cycles", 32'(n + LAT - 1), 32'd512);
        rd_chk("rdclr_010", 12'h010, 8'h00);

        // Reset mid-clear at row 100, then a full clear again
        wr(12'h5A3, 8'h5C);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (100) tick();
        check("midclr_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midclr_busy_abort", 32'(busy), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        run_clear(n, stray);
        check("reclr_cycles", 32'(n), 32'd512);
        check("reclr_no_rd_valid", 32'(stray), 32'd0);
        rd_chk("reclr_5a3", 12'h5A3, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lzw_dict_bank_ram.md
# lzw_dict_bank_ram

Parametrised, bank-interleaved, single-port dictionary RAM for the LZW compressor. It stores the append-character or prefix-code table, and is the generalised successor of the fixed 4K×8, 8-bank append-character RAM. It adds configurable width, depth and bank count, a read-valid strobe, a held read output and a hardware table-clear sequencer, so the encoder can reset its dictionary between blocks without software sweeps.

## Interface
- DATA_W, 8, entry width in bits
- ADDR_W, 12, entry address width; depth = 2^ADDR_W
- BANK_BITS, 3, log2 of bank count; NBANKS = 2^BANK_BITS, each bank 2^(ADDR_W-BANK_BITS) rows; legal range 0 to ADDR_W-1
- INIT_VAL, 0, value written to every entry by the clear sequencer
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  access request, ignored while busy=1
- wren  in  1  1 = write, 0 = read; qualified by en
- addr  in  ADDR_W  entry address; bank = addr[BANK_BITS-1:0], row = addr[ADDR_W-1:BANK_BITS]
- wr_data  in  DATA_W  write data
- rd_data  out  DATA_W  read data, held between reads
- rd_valid  out  1  one-cycle strobe: rd_data carries a new read result
- init_req  in  1  request a full-table clear
- busy  out  1  clear sequencer active

## Operation
- Banks: NBANKS synchronous single-port arrays.
  - Exactly one bank is enabled per access, selected by the addr low bits.
  - All banks share the row address and wr_data.
- Write (en=1, wren=1, busy=0): entry[addr] <= wr_data at the edge. rd_data and rd_valid are unaffected.
- Read (en=1, wren=0, busy=0):
  - The bank select is registered alongside the request.
  - The returned word is muxed from the registered select, not from the live addr. addr may change on the next cycle.
- Hold register: rd_data keeps the last read result until the next read completes. It is never driven from an unselected bank.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when init_req=1. Row counter loads 0 and busy=1.
  - In CLEAR, every cycle writes INIT_VAL to row[counter] of all banks simultaneously, then increments the counter.
  - CLEAR -> IDLE after row 2^(ADDR_W-BANK_BITS)-1 is written. busy deasserts on that same edge.
  - init_req in CLEAR is ignored, with no restart.
  - en/wren/addr in CLEAR are dropped: no write, no rd_valid.
- A read issued on the cycle init_req rises completes normally, and the FSM enters CLEAR on the same edge.
- Simultaneous en=1 and init_req=1 in IDLE: the access executes, then the clear starts.
- Reset:
  - Array contents are not reset.
  - rd_data=0, rd_valid=0, busy=0, FSM=IDLE, counter=0.
  - Assertion mid-clear aborts the clear. Contents are then undefined until a new init_req.
- Addresses are unsigned. The counter width is ADDR_W-BANK_BITS and it does not wrap past the last row.

## Timing
- Read latency:
  - Request at edge N gives rd_data/rd_valid valid after edge N+1.
  - rd_valid is high for exactly one cycle per read.
- Back-to-back reads sustain one result per cycle.
- Read-after-write to the same addr on the next cycle returns the new data.
- Write-to-read has no turnaround penalty.
- Clear duration:
  - busy is high for exactly 2^(ADDR_W-BANK_BITS) cycles, 512 with the defaults.
  - The first access is accepted on the cycle after busy falls.
- init_req is level-sampled. Holding it high re-triggers a new clear after CLEAR returns to IDLE.

## Configuration
- LZW_DICT_RAM_OUTREG_EN:
  - When defined, an output pipeline register follows the bank mux. Read latency becomes 2 cycles, and rd_valid is delayed identically.
  - Reset value of the extra stage is 0/0.
  - The hold behaviour applies to the final stage.
- When undefined, read latency is 1 cycle as specified above.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> rd_data=0, rd_valid=0, busy=0 immediately, without waiting for a clock.
- Write 0xC4 @0x5A3, then read 0x5A3 next cycle -> rd_data=0xC4 with rd_valid pulse one cycle later (two cycles with LZW_DICT_RAM_OUTREG_EN).
- Interleave: write addr 0x000..0x007 with 0x10..0x17, then read them back-to-back -> 0x10..0x17 on consecutive cycles, rd_valid high for 8 cycles.
- Hold: one read of 0x7FF=0x3E followed by 10 idle or write cycles -> rd_data stays 0x3E, rd_valid low.
- Clear: fill random data, pulse init_req -> busy high for exactly 512 cycles. en=1 during busy is ignored, with no rd_valid. Afterwards, reads of 0x000, 0x5A3 and 0xFFF return INIT_VAL.
- Reset mid-clear at row 100 -> busy=0 at once. A new init_req then runs a full 512-cycle clear.
